// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default geometry for the RGB pixel FIFO control blocks.
package fifo_ctrl_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CNT_W_DEF    = 16;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2,
        DROP     = 2'd3
    } wr_state_t;

endpackage

// File: rtl/frame_geom_tracker.sv
// Pixel/line position tracker with line-length and start-of-frame checks.
// Position x is the column of the next pixel, y is the current line.
// An SOF beat is always treated as column 0 / line 0 of a new frame.
module frame_geom_tracker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic wclk,
    input  logic wrst,
    input  logic in_frame,   // a frame is open; beats are checked against it
    input  logic s_valid,
    input  logic s_sof,
    input  logic s_eol,
    input  logic advance,    // the current beat was accepted into a frame
    output logic line_err,   // bad line length or SOF inside an open frame
    output logic frame_done  // beat closes the last line of the frame
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    // Classify the current beat against the expected geometry.
    always_comb begin
        cur_x      = s_sof ? '0 : x;
        cur_y      = s_sof ? '0 : y;
        line_err   = 1'b0;
        frame_done = 1'b0;
        if (s_valid && in_frame) begin
            line_err   = s_sof || (s_eol != (cur_x == X_LAST));
            frame_done = !s_sof && s_eol && (cur_x == X_LAST) && (cur_y == Y_LAST);
        end
    end

    // Advance the position on every accepted beat.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (s_eol) begin
                x <= '0;
                y <= cur_y + 1'b1;
            end else begin
                x <= cur_x + 1'b1;
                y <= cur_y;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_frame_ctrl.sv
// Write-side frame sequencer for the async RGB pixel FIFO (wclk domain).
// Admits whole frames only, checks geometry, aborts a frame on overflow,
// and keeps frame/drop counters plus sticky error flags.
//
// Stream contract: s_valid marks a pixel beat; there is no backpressure, so
// every beat is either written or discarded in the cycle it appears. On the
// FIFO side fifo_w_en is the write strobe; a strobe seen together with
// fifo_w_full means the FIFO rejected that pixel (overflow).
module fifo_wr_frame_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             enable,
    input  logic             s_valid,
    input  rgb_t             s_data,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             fifo_w_en,
    output rgb_t             fifo_w_data,
    input  logic             fifo_w_full,
    output logic             frame_active,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             err_overflow,
    output logic             err_geom,
    input  logic             clr_err,
    output wr_state_t        dbg_state
);

    wr_state_t state;
    logic      ovf;
    logic      sof_beat;
    logic      advance;
    logic      line_err;
    logic      frame_done;
    logic      geom_evt;
    logic      drop_evt;
    logic      ok_evt;
    // The last pixel of a finished frame is still in flight for one cycle;
    // the frame is only counted good once that write has not overflowed.
    logic      done_pend;

    assign ovf          = fifo_w_en & fifo_w_full;
    assign sof_beat     = s_valid & s_sof;
    assign frame_active = (state == PASS);
    assign dbg_state    = state;

    frame_geom_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_geom (
        .wclk       (wclk),
        .wrst       (wrst),
        .in_frame   (state == PASS),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .advance    (advance),
        .line_err   (line_err),
        .frame_done (frame_done)
    );

    // Decide whether this cycle's beat is written into the FIFO.
    always_comb begin
        advance = 1'b0;
        case (state)
            WAIT_SOF: advance = enable & sof_beat;
            PASS:     advance = !ovf && s_valid && (s_sof ? enable : !line_err);
            DROP:     advance = enable & sof_beat;
            default:  advance = 1'b0;
        endcase
    end

    assign geom_evt = (state == PASS) && !ovf && line_err;
    assign drop_evt = ((state == PASS) && (ovf || line_err)) || (done_pend && ovf);
    assign ok_evt   = done_pend && !ovf;

    // Frame sequencer and registered FIFO write port.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state       <= IDLE;
            fifo_w_en   <= 1'b0;
            fifo_w_data <= '0;
            done_pend   <= 1'b0;
        end else begin
            fifo_w_en <= advance;
            if (advance) begin
                fifo_w_data <= s_data;
            end
            done_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!enable)       state <= IDLE;
                    else if (sof_beat) state <= PASS;
                end
                PASS: begin
                    if (ovf) begin
                        state <= DROP;
                    end else if (s_valid) begin
                        if (s_sof) begin
                            state <= enable ? PASS : IDLE;
                        end else if (line_err) begin
                            state <= DROP;
                        end else if (frame_done) begin
                            done_pend <= 1'b1;
                            state     <= enable ? WAIT_SOF : IDLE;
                        end
                    end
                end
                DROP: begin
                    if (sof_beat) state <= enable ? PASS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating frame counters and sticky error flags (a new error wins over clr_err).
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            frames_ok      <= '0;
            frames_dropped <= '0;
            err_overflow   <= 1'b0;
            err_geom       <= 1'b0;
        end else begin
            if (ok_evt && (frames_ok != '1)) begin
                frames_ok <= frames_ok + 1'b1;
            end
            if (drop_evt && (frames_dropped != '1)) begin
                frames_dropped <= frames_dropped + 1'b1;
            end
            err_overflow <= ovf | (err_overflow & ~clr_err);
            err_geom     <= geom_evt | (err_geom & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_wr_frame_ctrl.sv
// Bench for fifo_wr_frame_ctrl with a small 4x2 frame geometry.
module tb_fifo_wr_frame_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic wclk = 1'b0;
    logic wrst = 1'b0;
    always #5 wclk = ~wclk;

    logic            enable = 1'b0;
    logic            s_valid = 1'b0;
    rgb_t            s_data = '0;
    logic            s_sof = 1'b0;
    logic            s_eol = 1'b0;
    logic            fifo_w_full = 1'b0;
    logic            clr_err = 1'b0;
    logic            fifo_w_en;
    rgb_t            fifo_w_data;
    logic            frame_active;
    logic [CW-1:0]   frames_ok;
    logic [CW-1:0]   frames_dropped;
    logic            err_overflow;
    logic            err_geom;
    wr_state_t       dbg_state;

    fifo_wr_frame_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CNT_W    (CW)
    ) dut (
        .wclk           (wclk),
        .wrst           (wrst),
        .enable         (enable),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_sof          (s_sof),
        .s_eol          (s_eol),
        .fifo_w_en      (fifo_w_en),
        .fifo_w_data    (fifo_w_data),
        .fifo_w_full    (fifo_w_full),
        .frame_active   (frame_active),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped),
        .err_overflow   (err_overflow),
        .err_geom       (err_geom),
        .clr_err        (clr_err),
        .dbg_state      (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Modes: off (not admitting), armed (looking for SOF), live (frame open),
    // gone (frame abandoned, waiting for the next SOF).
    localparam int M_OFF = 0, M_ARMED = 1, M_LIVE = 2, M_GONE = 3;
    logic [23:0] exp_q[$];   // pixels expected on the FIFO write port, in order
    int m_mode, m_col, m_row, m_ok, m_drop;
    bit m_wen, m_wnx, m_pend, m_eovf, m_egeom;
    bit g_en, g_full, g_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_col = 0; m_row = 0; m_ok = 0; m_drop = 0;
        m_wen = 0; m_wnx = 0; m_pend = 0; m_eovf = 0; m_egeom = 0;
        exp_q.delete();
    endtask

    task automatic model_take(input logic [23:0] d);
        m_mode = M_LIVE; m_col = 1; m_row = 0;
        exp_q.push_back(d);
        m_wnx = 1;
    endtask

    // One clock of the frame rules, given the inputs seen at that edge.
    task automatic model_clock(input bit v, input bit sof, input bit eol, input logic [23:0] d,
                               input bit en, input bit full, input bit clr);
        bit ovf;
        bit geo;
        ovf = m_wen && full;
        geo = 0;
        m_wnx = 0;
        if (m_pend) begin
            if (ovf) m_drop++;
            else     m_ok++;
        end
        m_pend = 0;
        case (m_mode)
            M_OFF:   if (en) m_mode = M_ARMED;
            M_ARMED: begin
                if (!en) m_mode = M_OFF;
                else if (v && sof) model_take(d);
            end
            M_LIVE: begin
                if (ovf) begin
                    m_drop++; m_mode = M_GONE;
                end else if (v) begin
                    if (sof) begin
                        geo = 1; m_drop++;
                        if (en) model_take(d);
                        else    m_mode = M_OFF;
                    end else if (eol != (m_col == H - 1)) begin
                        geo = 1; m_drop++; m_mode = M_GONE;
                    end else begin
                        exp_q.push_back(d);
                        m_wnx = 1;
                        if (!eol) m_col++;
                        else if (m_row == V - 1) begin
                            m_pend = 1;
                            m_mode = en ? M_ARMED : M_OFF;
                        end else begin
                            m_row++; m_col = 0;
                        end
                    end
                end
            end
            default: begin
                if (v && sof) begin
                    if (en) model_take(d);
                    else    m_mode = M_OFF;
                end
            end
        endcase
        m_wen   = m_wnx;
        m_eovf  = ovf | (m_eovf & !clr);
        m_egeom = geo | (m_egeom & !clr);
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_all();
        logic [23:0] e;
        check("w_en", fifo_w_en, m_wen);
        if (m_wen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("w_data", fifo_w_data, e);
        end
        check("frame_active", frame_active, (m_mode == M_LIVE));
        check("frames_ok", frames_ok, m_ok);
        check("frames_dropped", frames_dropped, m_drop);
        check("err_overflow", err_overflow, m_eovf);
        check("err_geom", err_geom, m_egeom);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic sof, input logic eol, input logic [23:0] d);
        s_valid = v; s_sof = sof; s_eol = eol; s_data = d;
        enable = g_en; fifo_w_full = g_full; clr_err = g_clr;
        @(posedge wclk);
        model_clock(v, sof, eol, d, g_en, g_full, g_clr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic do_reset();
        s_valid = 0; s_sof = 0; s_eol = 0; fifo_w_full = 0; clr_err = 0;
        wrst = 1'b1;
        #2;
        model_reset();
        check("rst_w_en", fifo_w_en, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frames_ok", frames_ok, 0);
        check("rst_frames_dropped", frames_dropped, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_geom", err_geom, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    // Whole frame; base+i is pixel i. full_at/en_off_at = -1 to disable.
    task automatic send_frame(input logic [23:0] base, input int full_at, input int en_off_at);
        for (int i = 0; i < H * V; i++) begin
            g_full = (i == full_at);
            if (i == en_off_at) g_en = 0;
            step(1'b1, (i == 0), ((i % H) == H - 1), base + 24'(i));
        end
        g_full = 0;
    endtask

    task automatic random_phase(input int n_frames);
        for (int f = 0; f < n_frames; f++) begin
            int corrupt;
            int bad_at;
            corrupt = $urandom_range(0, 5);
            bad_at  = $urandom_range(1, H * V - 1);
            if ($urandom_range(0, 7) == 0) g_en = ~g_en;
            else if (!g_en && $urandom_range(0, 1) == 1) g_en = 1;
            for (int i = 0; i < H * V; i++) begin
                bit sof;
                bit eol;
                sof = (i == 0);
                eol = ((i % H) == H - 1);
                if (i == bad_at && corrupt == 0) eol = ~eol;
                if (i == bad_at && corrupt == 1) begin sof = 1; eol = 0; end
                if ($urandom_range(0, 40) == 0) g_en = ~g_en;
                while ($urandom_range(0, 3) == 0) begin
                    g_full = ($urandom_range(0, 15) == 0);
                    g_clr  = ($urandom_range(0, 15) == 0);
                    step(1'b0, 1'b0, 1'b0, 24'($urandom));
                end
                g_full = ($urandom_range(0, 15) == 0);
                g_clr  = ($urandom_range(0, 15) == 0);
                step(1'b1, sof, eol, 24'($urandom));
            end
        end
        g_full = 0;
        g_clr  = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        g_en = 0; g_full = 0; g_clr = 0;
        model_reset();
        #1;
        do_reset();

        // clean frame
        g_en = 1;
        idle(2);
        send_frame(24'h000001, -1, -1);
        idle(2);
        check("clean_ok", frames_ok, 1);
        check("clean_drop", frames_dropped, 0);
        check("clean_geom", err_geom, 0);

        // overflow on the third write, then a clean frame
        send_frame(24'h000100, 3, -1);
        idle(2);
        check("ovf_flag", err_overflow, 1);
        check("ovf_drop", frames_dropped, 1);
        send_frame(24'h000200, -1, -1);
        idle(2);
        check("ovf_next_ok", frames_ok, 2);

        g_clr = 1; idle(1); g_clr = 0;
        check("clr_ovf", err_overflow, 0);

        // early EOL on the third pixel of line 0
        step(1, 1, 0, 24'h000300);
        step(1, 0, 0, 24'h000301);
        step(1, 0, 1, 24'h000302);
        check("eol_state_drop", dbg_state, DROP);
        step(1, 0, 0, 24'h000303);
        idle(2);
        check("eol_geom", err_geom, 1);
        check("eol_drop", frames_dropped, 2);
        send_frame(24'h000400, -1, -1);
        idle(2);
        check("eol_next_ok", frames_ok, 3);

        // SOF on pixel 5 restarts the frame
        for (int i = 0; i < H; i++) step(1, (i == 0), (i == H - 1), 24'h000500 + 24'(i));
        send_frame(24'h000600, -1, -1);
        idle(2);
        check("esof_drop", frames_dropped, 3);
        check("esof_ok", frames_ok, 4);
        check("esof_geom", err_geom, 1);

        // clr_err coinciding with a new geometry error keeps the flag
        step(1, 1, 0, 24'h000700);
        g_clr = 1;
        step(1, 0, 1, 24'h000701);
        g_clr = 0;
        check("clr_vs_err", err_geom, 1);
        check("clr_vs_err_drop", frames_dropped, 4);
        g_clr = 1; idle(1); g_clr = 0;
        check("clr_geom", err_geom, 0);

        // enable removed mid-frame: frame still completes, then idle
        idle(1);
        send_frame(24'h000800, -1, 2);
        idle(1);
        check("en_off_ok", frames_ok, 5);
        check("en_off_state", dbg_state, IDLE);
        send_frame(24'h000900, -1, -1);
        idle(2);
        check("en_off_ignored", frames_ok, 5);

        // reset mid-frame, then a clean frame
        g_en = 1;
        idle(2);
        step(1, 1, 0, 24'h000A00);
        step(1, 0, 0, 24'h000A01);
        step(1, 0, 0, 24'h000A02);
        do_reset();
        step(1, 0, 0, 24'h000A03);
        step(1, 0, 1, 24'h000A04);
        send_frame(24'h000B00, -1, -1);
        idle(2);
        check("post_rst_ok", frames_ok, 1);
        check("post_rst_drop", frames_dropped, 0);
        step(1, 1, 0, 24'h000C00);
        step(1, 0, 1, 24'h000C01);
        check("post_rst_geom", err_geom, 1);
        g_clr = 1; idle(1); g_clr = 0;
        check("post_rst_clr", err_geom, 0);

        // randomized traffic against the model
        g_en = 1;
        random_phase(200);
        g_en = 1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
